// File: rtl/bcd_counter_mux_display_pkg.sv
// Shared segment patterns and digit helpers for the multi-digit BCD counter display.
// Patterns are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package bcd_disp_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Any non-BCD code renders as a blank digit; this one is used on purpose for blanking.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit, input logic dp);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        pat[7] = ~dp;
        return pat;
    endfunction

endpackage

// File: rtl/bcd_counter_mux_display_if.sv
// Control/data bundle between the board-side driver and the BCD counter display.
interface bcd_counter_mux_display_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   din;
    logic                  en;
    logic                  up;
    logic [DIGITS-1:0]     dp_in;
    logic [4*DIGITS-1:0]   q;
    logic                  carry;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (output load, din, en, up, dp_in, input q, carry, seg, an);
    modport slave  (input load, din, en, up, dp_in, output q, carry, seg, an);
endinterface

// File: rtl/bcd_counter_mux_display_seg_scan_mux.sv
// Digit scanner: prescaler, digit index, leading-zero blanking and registered seg/an drive.
module seg_scan_mux
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] q,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] blank_vec;
    logic [3:0]        code_sel;
    logic              dp_sel;
    logic              zero_above;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        // Walk from the most-significant digit down; a digit is blank while everything above it is zero.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (q[4*k +: 4] == 4'd0);
            if (k > 0 && BLANK_LZ != 0) blank_vec[k] = zero_above;
        end
    end

    always_comb begin
        code_sel = 4'd0;
        dp_sel   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                code_sel = blank_vec[k] ? DIGIT_BLANK : q[4*k +: 4];
                dp_sel   = dp_in[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= ~DIGITS'(1);
            seg   <= SEG_0;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= bcd_to_seg(code_sel, dp_sel);
        end
    end

endmodule

// File: rtl/bcd_counter_mux_display.sv
// N-digit loadable BCD up/down counter with carry/borrow pulse, feeding a multiplexed 7-segment scanner.
module bcd_counter_mux_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input logic                       clk,
    input logic                       rst,
    bcd_counter_mux_display_if.slave  bus
);
    logic [4*DIGITS-1:0] q, q_next;
    logic                carry, carry_next;
    logic                wrap;
    logic [3:0]          d;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        wrap       = 1'b1;
        d          = 4'd0;
        if (bus.load) begin
            for (int i = 0; i < DIGITS; i++)
                q_next[4*i +: 4] = bcd_valid(bus.din[4*i +: 4]) ? bus.din[4*i +: 4] : 4'd0;
        end else if (bus.en) begin
            // wrap stays high only while every lower digit rolled over, so it doubles as the carry.
            for (int i = 0; i < DIGITS; i++) begin
                if (wrap) begin
                    d = q[4*i +: 4];
                    if (bus.up) begin
                        wrap             = (d == 4'd9);
                        q_next[4*i +: 4] = wrap ? 4'd0 : d + 4'd1;
                    end else begin
                        wrap             = (d == 4'd0);
                        q_next[4*i +: 4] = wrap ? 4'd9 : d - 4'd1;
                    end
                end
            end
            carry_next = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q     <= '0;
            carry <= 1'b0;
        end else begin
            q     <= q_next;
            carry <= carry_next;
        end
    end

    seg_scan_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .q     (q),
        .dp_in (bus.dp_in),
        .seg   (seg),
        .an    (an)
    );

    assign bus.q     = q;
    assign bus.carry = carry;
    assign bus.seg   = seg;
    assign bus.an    = an;

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Self-checking bench: directed steps plus random traffic against a decimal-arithmetic reference model.
module tb_bcd_counter_mux_display;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MODULUS  = 10000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_counter_mux_display_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter_mux_display #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state, in plain decimal terms.
    int         m_val;
    bit         m_carry;
    int         m_idx;
    int         m_presc;
    logic [7:0] m_seg;
    logic [3:0] m_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sanitize(input logic [15:0] din);
        int v = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int dg = int'(din[4*i +: 4]);
            v += ((dg > 9) ? 0 : dg) * pow10(i);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k, input logic dp);
        logic [7:0] p;
        if (k > 0 && v < pow10(k)) p = 8'hFF;
        else p = seg_tab[(v / pow10(k)) % 10];
        if (dp) p[7] = 1'b0;
        return p;
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare all outputs.
    task automatic tick();
        logic [3:0] one = 4'b0001;
        @(posedge clk);
        if (!rst) begin
            m_val = 0; m_carry = 0; m_idx = 0; m_presc = 0;
            m_an = 4'b1110; m_seg = 8'hC0;
        end else begin
            m_seg = exp_seg(m_val, m_idx, bus.dp_in[m_idx]);
            m_an  = ~(one << m_idx);
            if (m_presc == SCAN_DIV - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % DIGITS;
            end else begin
                m_presc++;
            end
            if (bus.load) begin
                m_val = sanitize(bus.din); m_carry = 0;
            end else if (bus.en) begin
                if (bus.up) begin
                    m_carry = (m_val == MODULUS - 1);
                    m_val   = (m_val + 1) % MODULUS;
                end else begin
                    m_carry = (m_val == 0);
                    m_val   = (m_val + MODULUS - 1) % MODULUS;
                end
            end else begin
                m_carry = 0;
            end
        end
        #1;
        check("q",     32'(bus.q),     32'(to_bcd(m_val)));
        check("carry", 32'(bus.carry), 32'(m_carry));
        check("an",    32'(bus.an),    32'(m_an));
        check("seg",   32'(bus.seg),   32'(m_seg));
    endtask

    task automatic drive(input logic l, input logic [15:0] d, input logic e, input logic u);
        bus.load = l; bus.din = d; bus.en = e; bus.up = u;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        bus.dp_in = '0;

        // Reset state.
        tick(); tick();
        check("rst_q",   32'(bus.q),     32'h0000);
        check("rst_car", 32'(bus.carry), 32'h0);
        check("rst_an",  32'(bus.an),    32'hE);
        check("rst_seg", 32'(bus.seg),   32'hC0);
        rst = 1'b1;

        // Ripple into the thousands digit.
        drive(1'b1, 16'h0999, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0, 1'b1, 1'b1); tick();
        check("inc_0999", 32'(bus.q), 32'h1000);
        check("inc_0999_car", 32'(bus.carry), 32'h0);

        // Up-wrap with one-cycle carry.
        drive(1'b1, 16'h9999, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0, 1'b1, 1'b1); tick();
        check("wrap_up_q", 32'(bus.q), 32'h0000);
        check("wrap_up_car", 32'(bus.carry), 32'h1);
        drive(1'b0, 16'h0, 1'b0, 1'b1); tick();
        check("wrap_up_pulse", 32'(bus.carry), 32'h0);

        // Down-wrap.
        drive(1'b1, 16'h0000, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0, 1'b1, 1'b0); tick();
        check("wrap_dn_q", 32'(bus.q), 32'h9999);
        check("wrap_dn_car", 32'(bus.carry), 32'h1);
        drive(1'b0, 16'h0, 1'b0, 1'b0); tick();
        check("wrap_dn_pulse", 32'(bus.carry), 32'h0);

        // Invalid digits zeroed; load beats enable.
        drive(1'b1, 16'h0A3F, 1'b0, 1'b1); tick();
        check("load_inv", 32'(bus.q), 32'h0030);
        drive(1'b1, 16'h0042, 1'b1, 1'b1); tick();
        check("load_en", 32'(bus.q), 32'h0042);
        check("load_en_car", 32'(bus.carry), 32'h0);

        // Scan of 0042 with leading-zero blanking, then with dp on digit 1.
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            tick();
            case (bus.an)
                4'b1110: check("scan_d0", 32'(bus.seg), 32'hA4);
                4'b1101: check("scan_d1", 32'(bus.seg), 32'h99);
                4'b1011: check("scan_d2", 32'(bus.seg), 32'h7F | 32'h80);
                4'b0111: check("scan_d3", 32'(bus.seg), 32'hFF);
                default: check("scan_onehot", 32'(bus.an), 32'hE);
            endcase
        end
        bus.dp_in = 4'b0010;
        for (int c = 0; c < 4 * SCAN_DIV + 1; c++) begin
            tick();
            if (bus.an == 4'b1101) check("scan_dp1", 32'(bus.seg), 32'h19);
        end
        bus.dp_in = '0;

        // Reset in the middle of counting.
        drive(1'b1, 16'h0000, 1'b0, 1'b1); tick();
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 37; c++) tick();
        check("cnt37", 32'(bus.q), 32'h0037);
        rst = 1'b0; tick();
        check("midrst_q",  32'(bus.q),  32'h0000);
        check("midrst_an", 32'(bus.an), 32'hE);
        rst = 1'b1; tick();
        check("resume", 32'(bus.q), 32'h0001);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            bus.load  = ($urandom_range(0, 9) == 0);
            bus.din   = 16'($urandom);
            bus.en    = $urandom_range(0, 1) == 1;
            bus.up    = $urandom_range(0, 1) == 1;
            bus.dp_in = 4'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
